// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MA-stage data memory responder with fixed access latency
// Byte-addressed little-endian array; sub-word loads extended per READ_UNSIGNED.
module dmem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  input  logic [1:0]  MEM_READ,
  input  logic [1:0]  MEM_WRITE,
  input  logic        READ_UNSIGNED,
  output logic [31:0] READ_DATA,
  output logic        BUSY_WAIT,
  output logic        MISALIGNED
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [1:0]           rsize_q, rsize_d;
  logic [1:0]           wsize_q, wsize_d;
  logic                 uns_q, uns_d;
  logic                 mis_q, mis_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [7:0]           mem_q [0:(1<<ADDR_BITS)-1];

  logic                 req;
  logic                 commit;
  logic [1:0]           eff_size;
  logic [ADDR_BITS-1:0] raw_addr, aligned_addr;
  logic                 mis_in;
  logic [ADDR_BITS-1:0] a1, a2, a3;
  logic [7:0]           b0, b1, b2, b3;
  logic [31:0]          load_val;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^ADDRESS[31:ADDR_BITS];
  assign req = (MEM_READ != 2'b00) || (MEM_WRITE != 2'b00);

  // A combined read+write request is aligned by the write size, since that is the access performed.
  always_comb begin
    raw_addr     = ADDRESS[ADDR_BITS-1:0];
    eff_size     = (MEM_WRITE != 2'b00) ? MEM_WRITE : MEM_READ;
    aligned_addr = raw_addr;
    mis_in       = 1'b0;
    if (eff_size == 2'b10) begin
      aligned_addr[0] = 1'b0;
      mis_in          = raw_addr[0];
    end else if (eff_size == 2'b11) begin
      aligned_addr[1:0] = 2'b00;
      mis_in            = |raw_addr[1:0];
    end
  end

  always_comb begin
    a1 = addr_q + ADDR_BITS'(1);
    a2 = addr_q + ADDR_BITS'(2);
    a3 = addr_q + ADDR_BITS'(3);
    b0 = mem_q[addr_q];
    b1 = mem_q[a1];
    b2 = mem_q[a2];
    b3 = mem_q[a3];
    load_val = 32'h0;
    case (rsize_q)
      2'b01:   load_val = uns_q ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b10:   load_val = uns_q ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      2'b11:   load_val = {b3, b2, b1, b0};
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rsize_d = rsize_q;
    wsize_d = wsize_q;
    uns_d   = uns_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACCESS;
          cnt_d   = 4'(LATENCY);
          addr_d  = aligned_addr;
          wdata_d = WRITE_DATA;
          rsize_d = MEM_READ;
          wsize_d = MEM_WRITE;
          uns_d   = READ_UNSIGNED;
          mis_d   = mis_in;
        end
      end
      ACCESS: begin
        // Pipeline withdrawing the request (flush) abandons the access.
        if (!req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = DONE;
          cnt_d   = 4'd0;
          if (rsize_q != 2'b00) rdata_d = (wsize_q != 2'b00) ? 32'h0 : load_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rsize_q <= 2'b00;
      wsize_q <= 2'b00;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsize_q <= rsize_d;
      wsize_q <= wsize_d;
      uns_q   <= uns_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (commit) begin
      if (wsize_q != 2'b00) mem_q[addr_q] <= wdata_q[7:0];
      if (wsize_q[1])       mem_q[a1]     <= wdata_q[15:8];
      if (wsize_q == 2'b11) begin
        mem_q[a2] <= wdata_q[23:16];
        mem_q[a3] <= wdata_q[31:24];
      end
    end
  end

  assign READ_DATA  = rdata_q;
  assign BUSY_WAIT  = RESET && ((state_q == ACCESS) || ((state_q == IDLE) && req));
  assign MISALIGNED = (state_q == DONE) && mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
// Expected load results are queued at drive time and popped at the DONE cycle.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [1:0]  MEM_READ;
  logic [1:0]  MEM_WRITE;
  logic        READ_UNSIGNED;
  logic [31:0] READ_DATA;
  logic        BUSY_WAIT;
  logic        MISALIGNED;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rd  = 32'h0;

  dmem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ADDRESS(ADDRESS),
    .WRITE_DATA(WRITE_DATA),
    .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE),
    .READ_UNSIGNED(READ_UNSIGNED),
    .READ_DATA(READ_DATA),
    .BUSY_WAIT(BUSY_WAIT),
    .MISALIGNED(MISALIGNED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic uns);
    MEM_READ      = rd;
    MEM_WRITE     = wr;
    ADDRESS       = addr;
    WRITE_DATA    = wd;
    READ_UNSIGNED = uns;
  endtask

  task automatic push_exp(input string tag, input logic [1:0] rd, input logic [1:0] wr,
                          input logic [31:0] exp_rd, input logic exp_mis);
    exp_t e;
    e.tag = tag;
    if (rd == 2'b00)      e.rdata = last_rd;
    else if (wr != 2'b00) e.rdata = 32'h0;
    else                  e.rdata = exp_rd;
    e.mis   = exp_mis;
    last_rd = e.rdata;
    sb_q.push_back(e);
  endtask

  // Counts BUSY_WAIT cycles from the current sample point until the DONE cycle, then scores it.
  task automatic serve();
    int   nbusy;
    bit   done;
    exp_t e;
    nbusy = 0;
    done  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!BUSY_WAIT) begin
        done = 1'b1;
        break;
      end
      nbusy++;
      @(negedge CLK);
    end
    e = sb_q.pop_front();
    check({e.tag, "_done_seen"}, 32'(done), 32'd1);
    check({e.tag, "_busy_cycles"}, nbusy, LAT + 1);
    check({e.tag, "_rdata"}, READ_DATA, e.rdata);
    check({e.tag, "_mis"}, 32'(MISALIGNED), 32'(e.mis));
  endtask

  task automatic txn(input string tag, input logic [1:0] rd, input logic [1:0] wr,
                     input logic [31:0] addr, input logic [31:0] wd, input logic uns,
                     input logic [31:0] exp_rd, input logic exp_mis);
    @(negedge CLK);
    drive(rd, wr, addr, wd, uns);
    push_exp(tag, rd, wr, exp_rd, exp_mis);
    #1;
    serve();
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check({tag, "_mis_pulse_end"}, 32'(MISALIGNED), 32'd0);
    check({tag, "_idle_busy"}, 32'(BUSY_WAIT), 32'd0);
  endtask

  initial begin
    RESET = 1'b0;
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(BUSY_WAIT), 32'd0);
    check("rst_rdata", READ_DATA, 32'h0);
    check("rst_mis", 32'(MISALIGNED), 32'd0);
    RESET = 1'b1;

    txn("sw_init", 2'b00, 2'b11, 32'h10, 32'h11223344, 1'b0, 32'h0, 1'b0);

    // Reset asserted in the middle of an ACCESS must abandon the store.
    @(negedge CLK);
    drive(2'b00, 2'b11, 32'h10, 32'hDEADBEEF, 1'b0);
    @(negedge CLK);
    check("rstmid_busy_before", 32'(BUSY_WAIT), 32'd1);
    #1 RESET = 1'b0;
    #1;
    check("rstmid_busy_forced", 32'(BUSY_WAIT), 32'd0);
    check("rstmid_rdata", READ_DATA, 32'h0);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    RESET   = 1'b1;
    last_rd = 32'h0;
    txn("lw_after_rst", 2'b11, 2'b00, 32'h10, 32'h0, 1'b0, 32'h11223344, 1'b0);

    txn("sw_deadbeef", 2'b00, 2'b11, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    txn("lw_deadbeef", 2'b11, 2'b00, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
    txn("lb_13",  2'b01, 2'b00, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE, 1'b0);
    txn("lbu_13", 2'b01, 2'b00, 32'h13, 32'h0, 1'b1, 32'h000000DE, 1'b0);
    txn("lh_12",  2'b10, 2'b00, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD, 1'b0);
    txn("lhu_10", 2'b10, 2'b00, 32'h10, 32'h0, 1'b1, 32'h0000BEEF, 1'b0);

    txn("sb_11",  2'b00, 2'b01, 32'h11, 32'hFFFFFF55, 1'b0, 32'h0, 1'b0);
    txn("lw_sb",  2'b11, 2'b00, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 1'b0);
    txn("lh_mis", 2'b10, 2'b00, 32'h11, 32'h0, 1'b0, 32'h000055EF, 1'b1);

    txn("sw_wrap", 2'b00, 2'b11, 32'h400, 32'h12345678, 1'b0, 32'h0, 1'b0);
    txn("lw_wrap", 2'b11, 2'b00, 32'h000, 32'h0, 1'b0, 32'h12345678, 1'b0);

    txn("rw_both", 2'b11, 2'b01, 32'h30, 32'h000000A5, 1'b0, 32'h0, 1'b0);
    txn("lbu_30",  2'b01, 2'b00, 32'h30, 32'h0, 1'b1, 32'h000000A5, 1'b0);

    txn("sw_mis23", 2'b00, 2'b11, 32'h23, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1);
    txn("lw_20",    2'b11, 2'b00, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);

    // Request withdrawn during the second ACCESS cycle.
    @(negedge CLK);
    drive(2'b00, 2'b11, 32'h20, 32'hAAAAAAAA, 1'b0);
    #1 check("abort_busy_idle", 32'(BUSY_WAIT), 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    check("abort_busy_acc2", 32'(BUSY_WAIT), 32'd1);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check("abort_busy_low", 32'(BUSY_WAIT), 32'd0);
    check("abort_rdata", READ_DATA, last_rd);
    check("abort_no_mis", 32'(MISALIGNED), 32'd0);
    @(negedge CLK);
    check("abort_still_idle", 32'(BUSY_WAIT), 32'd0);
    txn("lw_after_abort", 2'b11, 2'b00, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);

    // Held request is served twice with a single non-busy DONE cycle between.
    @(negedge CLK);
    drive(2'b11, 2'b00, 32'h10, 32'h0, 1'b0);
    push_exp("held1", 2'b11, 2'b00, 32'hDEAD55EF, 1'b0);
    push_exp("held2", 2'b11, 2'b00, 32'hDEAD55EF, 1'b0);
    #1;
    serve();
    @(negedge CLK);
    check("held_gap_one_cycle", 32'(BUSY_WAIT), 32'd1);
    serve();
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check("held_end_idle", 32'(BUSY_WAIT), 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MA-stage memory interface of the pipelined RV32IM core.
- Accepts address, store data and 2-bit read/write size requests; performs byte, halfword or word accesses to an internal byte-addressed array.
- Holds the pipeline with BUSY_WAIT for a configurable latency, then returns load data (sign- or zero-extended) for the MA_WB register.

Parameters:
- ADDR_BITS, 10, byte-address width of storage; array holds 2^ADDR_BITS bytes.
- LATENCY, 2, ACCESS cycles per request; legal range 1..15.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- ADDRESS  input  32  byte address, driven from the EX_MA ALU result.
- WRITE_DATA  input  32  store data; byte in [7:0], halfword in [15:0].
- MEM_READ  input  2  00 none, 01 byte, 10 halfword, 11 word.
- MEM_WRITE  input  2  00 none, 01 byte, 10 halfword, 11 word.
- READ_UNSIGNED  input  1  1 zero-extends byte/halfword loads (LBU/LHU); 0 sign-extends.
- READ_DATA  output  32  load result; registered.
- BUSY_WAIT  output  1  stall request to the pipeline.
- MISALIGNED  output  1  one-cycle pulse in DONE when the request address was misaligned.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state IDLE, counter 0, READ_DATA 0, MISALIGNED 0.
  - BUSY_WAIT is forced to 0 while RESET=0.
  - Array contents are not cleared.
  - Reset mid-ACCESS abandons the request; no write is committed.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If MEM_READ!=00 or MEM_WRITE!=00, BUSY_WAIT=1 combinationally in the same cycle.
  - At the next edge, latch ADDRESS, WRITE_DATA, size, direction and READ_UNSIGNED, load counter=LATENCY, go to ACCESS.
- ACCESS:
  - BUSY_WAIT=1; counter decrements each edge.
  - On the edge where counter==1: commit the write to the array, load READ_DATA, go to DONE.
  - Latched values are used throughout; input changes during ACCESS are ignored.
  - Abort: if MEM_READ==00 and MEM_WRITE==00 at an ACCESS edge, return to IDLE; no write, READ_DATA unchanged.
- DONE:
  - BUSY_WAIT=0; READ_DATA is valid; MISALIGNED pulses if applicable.
  - Unconditionally return to IDLE at the next edge.
  - A request present in IDLE on the following cycle is treated as new, so a held request is served exactly once per pipeline advance.
- Total stall is LATENCY+1 cycles of BUSY_WAIT=1, followed by one DONE cycle.
- Addressing:
  - Index = ADDRESS[ADDR_BITS-1:0]; upper bits are ignored, so addresses wrap.
  - Halfword forces bit0=0; word forces bits[1:0]=00.
  - MISALIGNED is set if any forced bit was 1.
  - Little-endian byte order.
- Write sizes: byte writes WRITE_DATA[7:0]; halfword writes [15:0]; word writes [31:0]. Other bytes are untouched.
- Read sizes:
  - Byte and halfword are extended per READ_UNSIGNED.
  - Word returns 4 bytes.
  - READ_UNSIGNED is ignored for words.
- Simultaneous read and write (both nonzero): the write is performed with MEM_WRITE size; READ_DATA=0 in DONE.
- Write-only request: READ_DATA is left unchanged.

Test Plan:
- Reset low mid-ACCESS of SW 0xDEADBEEF @0x10 → BUSY_WAIT=0 immediately, state IDLE; later LW @0x10 does not return 0xDEADBEEF.
- SW 0xDEADBEEF @0x10, then LW @0x10 (LATENCY=2) → BUSY_WAIT high exactly 3 cycles per request; DONE cycle READ_DATA=0xDEADBEEF.
- After that store: LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- SB 0x55 @0x11 over word 0xDEADBEEF → LW @0x10 returns 0xDEAD55EF; LH @0x11 returns 0x000055EF with MISALIGNED=1 for one cycle.
- Address wrap (ADDR_BITS=10): SW 0x12345678 @0x400 → LW @0x000 returns 0x12345678.
- Request dropped to 00/00 on 2nd ACCESS cycle of SW 0xAAAAAAAA @0x20 → back to IDLE, no DONE; LW @0x20 returns prior contents. Held request across DONE → served twice, with BUSY_WAIT low for exactly one cycle between.
